// File: rtl/noc_isolation_ctrl_if.sv
// AW/AR address gating and B/R response observation signals between an AXI
// initiator, its isolation fence and the NoC ingress.
interface noc_isolation_ctrl_if;
  logic aw_valid_i;
  logic aw_ready_o;
  logic aw_valid_o;
  logic aw_ready_i;
  logic ar_valid_i;
  logic ar_ready_o;
  logic ar_valid_o;
  logic ar_ready_i;
  logic b_valid_i;
  logic b_ready_i;
  logic r_valid_i;
  logic r_ready_i;
  logic r_last_i;

  modport slave (
    input  aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
    input  b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i,
    output aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o
  );

  modport master (
    output aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
    output b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i,
    input  aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o
  );
endinterface

// File: rtl/noc_isolation_ctrl.sv
// Per-port fence for one NoC AXI initiator: throttles AW/AR at an outstanding
// limit, and on request blocks new addresses, drains responses, reports isolated.
module noc_isolation_ctrl #(
  parameter int MaxOutstanding = 64,
  parameter int CntWidth       = $clog2(MaxOutstanding + 1),
  parameter int TimeoutCycles  = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  noc_isolation_ctrl_if.slave bus,
  input  logic                isolate_req_i,
  output logic                isolate_ack_o,
  output logic                idle_o,
  output logic                timeout_o,
  output logic                err_o,
  output logic [CntWidth-1:0] wr_cnt_o,
  output logic [CntWidth-1:0] rd_cnt_o
);

  localparam int ToWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
  localparam logic [ToWidth-1:0]  ToLimit = ToWidth'(TimeoutCycles);
  localparam logic                ToEn    = (TimeoutCycles != 0);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    ISOLATED
  } state_e;

  state_e              state;
  state_e              state_nxt;
  logic                aw_pend;
  logic                ar_pend;
  logic                aw_pend_nxt;
  logic                ar_pend_nxt;
  logic                aw_gate;
  logic                ar_gate;
  logic                aw_hs;
  logic                ar_hs;
  logic                b_hs;
  logic                r_hs;
  logic                wr_underflow;
  logic                rd_underflow;
  logic [CntWidth-1:0] wr_cnt_nxt;
  logic [CntWidth-1:0] rd_cnt_nxt;
  logic [ToWidth-1:0]  to_cnt;

  // Returns {underflow, next count}; a decrement at zero holds the count at 0.
  function automatic logic [CntWidth:0] step_cnt(input logic [CntWidth-1:0] cnt,
                                                 input logic inc, input logic dec);
    logic [CntWidth-1:0] nxt;
    logic                uf;
    nxt = cnt;
    uf  = 1'b0;
    if (inc && !dec) begin
      nxt = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt == '0) uf = 1'b1;
      else           nxt = cnt - 1'b1;
    end
    return {uf, nxt};
  endfunction

  // A pending address keeps its gate open so a presented valid is never withdrawn.
  assign aw_gate = ((state == RUN) && (wr_cnt_o < MaxCnt)) || aw_pend;
  assign ar_gate = ((state == RUN) && (rd_cnt_o < MaxCnt)) || ar_pend;

  assign bus.aw_valid_o = aw_gate & bus.aw_valid_i;
  assign bus.aw_ready_o = aw_gate & bus.aw_ready_i;
  assign bus.ar_valid_o = ar_gate & bus.ar_valid_i;
  assign bus.ar_ready_o = ar_gate & bus.ar_ready_i;

  assign aw_hs = bus.aw_valid_o & bus.aw_ready_i;
  assign ar_hs = bus.ar_valid_o & bus.ar_ready_i;
  assign b_hs  = bus.b_valid_i & bus.b_ready_i;
  assign r_hs  = bus.r_valid_i & bus.r_ready_i & bus.r_last_i;

  assign aw_pend_nxt = bus.aw_valid_o & ~bus.aw_ready_i;
  assign ar_pend_nxt = bus.ar_valid_o & ~bus.ar_ready_i;

  always_comb begin
    {wr_underflow, wr_cnt_nxt} = step_cnt(wr_cnt_o, aw_hs, b_hs);
    {rd_underflow, rd_cnt_nxt} = step_cnt(rd_cnt_o, ar_hs, r_hs);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (isolate_req_i) state_nxt = DRAIN;
      DRAIN: begin
        if (!isolate_req_i) state_nxt = RUN;
        else if (idle_o)    state_nxt = ISOLATED;
      end
      ISOLATED: if (!isolate_req_i) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      wr_cnt_o      <= '0;
      rd_cnt_o      <= '0;
      aw_pend       <= 1'b0;
      ar_pend       <= 1'b0;
      err_o         <= 1'b0;
      idle_o        <= 1'b1;
      isolate_ack_o <= 1'b0;
      to_cnt        <= '0;
      timeout_o     <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_cnt_o      <= wr_cnt_nxt;
      rd_cnt_o      <= rd_cnt_nxt;
      aw_pend       <= aw_pend_nxt;
      ar_pend       <= ar_pend_nxt;
      err_o         <= err_o | wr_underflow | rd_underflow;
      // idle reflects post-edge counters so DRAIN can leave one cycle after the last response
      idle_o        <= (wr_cnt_nxt == '0) && (rd_cnt_nxt == '0) && !aw_pend_nxt && !ar_pend_nxt;
      isolate_ack_o <= (state == ISOLATED);
      if ((state == DRAIN) && (state_nxt == DRAIN)) begin
        if (to_cnt != ToLimit) to_cnt <= to_cnt + 1'b1;
        timeout_o <= ToEn && (to_cnt >= ToLimit - 1'b1);
      end else begin
        to_cnt    <= '0;
        timeout_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_isolation_ctrl.sv
// Bench for noc_isolation_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_noc_isolation_ctrl;
  localparam int Max = 4;
  localparam int Tmo = 8;
  localparam int CW  = $clog2(Max + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          isolate_req_i;
  logic          isolate_ack_o;
  logic          idle_o;
  logic          timeout_o;
  logic          err_o;
  logic [CW-1:0] wr_cnt_o;
  logic [CW-1:0] rd_cnt_o;

  noc_isolation_ctrl_if bus ();

  noc_isolation_ctrl #(
    .MaxOutstanding(Max),
    .TimeoutCycles (Tmo)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus),
    .isolate_req_i(isolate_req_i),
    .isolate_ack_o(isolate_ack_o),
    .idle_o       (idle_o),
    .timeout_o    (timeout_o),
    .err_o        (err_o),
    .wr_cnt_o     (wr_cnt_o),
    .rd_cnt_o     (rd_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = running, 1 = draining, 2 = isolated
  int m_mode, m_wr, m_rd, m_tcnt;
  bit m_awp, m_arp, m_err, m_idle, m_ack, m_to;

  function automatic void m_reset();
    m_mode = 0; m_wr = 0; m_rd = 0; m_tcnt = 0;
    m_awp = 0; m_arp = 0; m_err = 0; m_idle = 1; m_ack = 0; m_to = 0;
  endfunction

  function automatic bit m_gate_aw();
    return ((m_mode == 0) && (m_wr < Max)) || m_awp;
  endfunction

  function automatic bit m_gate_ar();
    return ((m_mode == 0) && (m_rd < Max)) || m_arp;
  endfunction

  task automatic model_update();
    bit aw_hs, ar_hs, b_hs, r_hs;
    int old_mode;
    if (rst_i) begin
      m_reset();
      return;
    end
    aw_hs = m_gate_aw() && bus.aw_valid_i && bus.aw_ready_i;
    ar_hs = m_gate_ar() && bus.ar_valid_i && bus.ar_ready_i;
    b_hs  = bus.b_valid_i && bus.b_ready_i;
    r_hs  = bus.r_valid_i && bus.r_ready_i && bus.r_last_i;
    m_awp = m_gate_aw() && bus.aw_valid_i && !bus.aw_ready_i;
    m_arp = m_gate_ar() && bus.ar_valid_i && !bus.ar_ready_i;
    if (b_hs && !aw_hs && m_wr == 0) m_err = 1;
    else m_wr = m_wr + int'(aw_hs) - int'(b_hs);
    if (r_hs && !ar_hs && m_rd == 0) m_err = 1;
    else m_rd = m_rd + int'(ar_hs) - int'(r_hs);
    old_mode = m_mode;
    m_ack = (old_mode == 2);
    case (old_mode)
      0: if (isolate_req_i) m_mode = 1;
      1: if (!isolate_req_i) m_mode = 0; else if (m_idle) m_mode = 2;
      default: if (!isolate_req_i) m_mode = 0;
    endcase
    if (old_mode == 1 && m_mode == 1) begin
      if (m_tcnt < Tmo) m_tcnt++;
      m_to = (m_tcnt >= Tmo);
    end else begin
      m_tcnt = 0;
      m_to = 0;
    end
    m_idle = (m_wr == 0) && (m_rd == 0) && !m_awp && !m_arp;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.aw_valid_i = 0; bus.aw_ready_i = 0;
    bus.ar_valid_i = 0; bus.ar_ready_i = 0;
    bus.b_valid_i = 0; bus.b_ready_i = 0;
    bus.r_valid_i = 0; bus.r_ready_i = 0; bus.r_last_i = 0;
  endtask

  task automatic test_reset();
    logic [3+2*CW:0] got;
    rst_i = 1; isolate_req_i = 0; idle_inputs(); m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    got = {isolate_ack_o, idle_o, timeout_o, err_o, wr_cnt_o, rd_cnt_o};
    checks++;
    if (got !== {4'b0100, {(2*CW){1'b0}}}) begin
      errors++; $display("FAIL reset_regs: got %b want %b", got, {4'b0100, {(2*CW){1'b0}}});
    end
    checks++;
    if ({bus.aw_valid_o, bus.aw_ready_o, bus.ar_valid_o, bus.ar_ready_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_gated: got %b want 0000",
                         {bus.aw_valid_o, bus.aw_ready_o, bus.ar_valid_o, bus.ar_ready_o});
    end
    rst_i = 0;
  endtask

  task automatic test_write_count();
    idle_inputs();
    bus.aw_valid_i = 1; bus.aw_ready_i = 1;
    repeat (3) tick();
    idle_inputs();
    bus.b_valid_i = 1; bus.b_ready_i = 1;
    repeat (2) tick();
    idle_inputs();
    checks++;
    if ({wr_cnt_o, idle_o, err_o} !== {3'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL write_count: got cnt=%0d idle=%b err=%b want cnt=1 idle=0 err=0",
                         wr_cnt_o, idle_o, err_o);
    end
    bus.b_valid_i = 1; bus.b_ready_i = 1;
    tick();
    idle_inputs();
    checks++;
    if ({wr_cnt_o, idle_o} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL write_idle: got cnt=%0d idle=%b want cnt=0 idle=1", wr_cnt_o, idle_o);
    end
  endtask

  task automatic test_throttle();
    idle_inputs();
    bus.ar_valid_i = 1; bus.ar_ready_i = 1;
    repeat (4) tick();
    checks++;
    if ({bus.ar_valid_o, bus.ar_ready_o, rd_cnt_o} !== {2'b00, 3'd4}) begin
      errors++; $display("FAIL throttle_block: got v=%b r=%b cnt=%0d want v=0 r=0 cnt=4",
                         bus.ar_valid_o, bus.ar_ready_o, rd_cnt_o);
    end
    bus.r_valid_i = 1; bus.r_ready_i = 1; bus.r_last_i = 1;
    tick();
    bus.r_valid_i = 0; bus.r_ready_i = 0; bus.r_last_i = 0;
    #1;
    checks++;
    if ({bus.ar_valid_o, bus.ar_ready_o, rd_cnt_o} !== {2'b11, 3'd3}) begin
      errors++; $display("FAIL throttle_reopen: got v=%b r=%b cnt=%0d want v=1 r=1 cnt=3",
                         bus.ar_valid_o, bus.ar_ready_o, rd_cnt_o);
    end
    tick();
    bus.ar_valid_i = 0; bus.ar_ready_i = 0;
    checks++;
    if (rd_cnt_o !== 3'd4) begin
      errors++; $display("FAIL throttle_accept: got %0d want 4", rd_cnt_o);
    end
    bus.r_valid_i = 1; bus.r_ready_i = 1; bus.r_last_i = 0;
    tick();
    checks++;
    if (rd_cnt_o !== 3'd4) begin
      errors++; $display("FAIL r_not_last: got %0d want 4", rd_cnt_o);
    end
    bus.r_last_i = 1;
    repeat (4) tick();
    idle_inputs();
    checks++;
    if ({rd_cnt_o, err_o} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL read_drain: got cnt=%0d err=%b want cnt=0 err=0", rd_cnt_o, err_o);
    end
  endtask

  task automatic test_drain();
    idle_inputs();
    bus.aw_valid_i = 1; bus.aw_ready_i = 1;
    repeat (2) tick();
    bus.aw_valid_i = 0; isolate_req_i = 1;
    tick();
    bus.aw_valid_i = 1;
    #1;
    checks++;
    if ({bus.aw_valid_o, bus.aw_ready_o} !== 2'b00) begin
      errors++; $display("FAIL drain_block_aw: got %b want 00", {bus.aw_valid_o, bus.aw_ready_o});
    end
    tick();
    bus.b_valid_i = 1; bus.b_ready_i = 1;
    repeat (2) tick();
    bus.b_valid_i = 0; bus.b_ready_i = 0;
    checks++;
    if ({isolate_ack_o, idle_o, wr_cnt_o} !== {2'b01, 3'd0}) begin
      errors++; $display("FAIL drain_last_b: got ack=%b idle=%b cnt=%0d want ack=0 idle=1 cnt=0",
                         isolate_ack_o, idle_o, wr_cnt_o);
    end
    tick();
    checks++;
    if (isolate_ack_o !== 1'b0) begin
      errors++; $display("FAIL ack_early: got %b want 0", isolate_ack_o);
    end
    tick();
    checks++;
    if (isolate_ack_o !== 1'b1) begin
      errors++; $display("FAIL ack_t2: got %b want 1", isolate_ack_o);
    end
    bus.aw_valid_i = 0; bus.aw_ready_i = 0; isolate_req_i = 0;
    tick();
    checks++;
    if (isolate_ack_o !== 1'b1) begin
      errors++; $display("FAIL ack_hold: got %b want 1", isolate_ack_o);
    end
    tick();
    checks++;
    if (isolate_ack_o !== 1'b0) begin
      errors++; $display("FAIL ack_release: got %b want 0", isolate_ack_o);
    end
  endtask

  task automatic test_pending_fence();
    idle_inputs();
    bus.aw_valid_i = 1; bus.aw_ready_i = 0;
    tick();
    isolate_req_i = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.aw_valid_o, wr_cnt_o, isolate_ack_o} !== {1'b1, 3'd0, 1'b0}) begin
        errors++; $display("FAIL pending_hold[%0d]: got v=%b cnt=%0d ack=%b want v=1 cnt=0 ack=0",
                           i, bus.aw_valid_o, wr_cnt_o, isolate_ack_o);
      end
    end
    bus.aw_ready_i = 1;
    tick();
    checks++;
    if ({bus.aw_valid_o, wr_cnt_o} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL pending_accept: got v=%b cnt=%0d want v=0 cnt=1", bus.aw_valid_o, wr_cnt_o);
    end
    idle_inputs();
    bus.b_valid_i = 1; bus.b_ready_i = 1;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (isolate_ack_o !== 1'b0) begin
      errors++; $display("FAIL pending_ack_early: got %b want 0", isolate_ack_o);
    end
    tick();
    checks++;
    if (isolate_ack_o !== 1'b1) begin
      errors++; $display("FAIL pending_ack: got %b want 1", isolate_ack_o);
    end
    isolate_req_i = 0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    idle_inputs();
    bus.ar_valid_i = 1; bus.ar_ready_i = 1;
    tick();
    idle_inputs(); isolate_req_i = 1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (timeout_o !== (k >= Tmo)) begin
        errors++; $display("FAIL timeout_cycle[%0d]: got %b want %b", k, timeout_o, (k >= Tmo));
      end
    end
    isolate_req_i = 0;
    tick();
    bus.ar_valid_i = 1; bus.ar_ready_i = 1;
    #1;
    checks++;
    if ({timeout_o, bus.ar_valid_o} !== 2'b01) begin
      errors++; $display("FAIL timeout_abort: got to=%b arv=%b want to=0 arv=1", timeout_o, bus.ar_valid_o);
    end
    idle_inputs();
    bus.r_valid_i = 1; bus.r_ready_i = 1; bus.r_last_i = 1;
    tick();
    idle_inputs();
  endtask

  task automatic test_err();
    idle_inputs();
    bus.b_valid_i = 1; bus.b_ready_i = 1;
    tick();
    idle_inputs();
    checks++;
    if ({err_o, wr_cnt_o} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL err_underflow: got err=%b cnt=%0d want err=1 cnt=0", err_o, wr_cnt_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", err_o);
    end
    bus.aw_valid_i = 1; bus.aw_ready_i = 1;
    repeat (2) tick();
    bus.b_valid_i = 1; bus.b_ready_i = 1;
    tick();
    checks++;
    if (wr_cnt_o !== 3'd2) begin
      errors++; $display("FAIL simul_aw_b: got %0d want 2", wr_cnt_o);
    end
    bus.aw_valid_i = 0; bus.aw_ready_i = 0;
    repeat (2) tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_drain();
    logic [3+2*CW:0] got;
    idle_inputs();
    bus.aw_valid_i = 1; bus.aw_ready_i = 1;
    tick();
    idle_inputs(); isolate_req_i = 1;
    repeat (2) tick();
    #2;
    rst_i = 1;
    #1;
    m_reset();
    got = {isolate_ack_o, idle_o, timeout_o, err_o, wr_cnt_o, rd_cnt_o};
    checks++;
    if (got !== {4'b0100, {(2*CW){1'b0}}}) begin
      errors++; $display("FAIL async_reset: got %b want %b", got, {4'b0100, {(2*CW){1'b0}}});
    end
    isolate_req_i = 0;
    tick();
    rst_i = 0;
  endtask

  task automatic test_random();
    logic [3:0]      got_c, exp_c;
    logic [3+2*CW:0] got_r, exp_r;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 29) == 0) isolate_req_i = ~isolate_req_i;
      bus.aw_valid_i = 1'($urandom_range(0, 1));
      bus.aw_ready_i = ($urandom_range(0, 4) < 3);
      bus.ar_valid_i = 1'($urandom_range(0, 1));
      bus.ar_ready_i = ($urandom_range(0, 4) < 3);
      bus.b_valid_i  = (m_wr > 0) && ($urandom_range(0, 2) != 0);
      bus.b_ready_i  = 1'($urandom_range(0, 1));
      bus.r_valid_i  = (m_rd > 0) && ($urandom_range(0, 2) != 0);
      bus.r_ready_i  = 1'($urandom_range(0, 1));
      bus.r_last_i   = 1'($urandom_range(0, 1));
      #1;
      exp_c = {m_gate_aw() & bus.aw_valid_i, m_gate_aw() & bus.aw_ready_i,
               m_gate_ar() & bus.ar_valid_i, m_gate_ar() & bus.ar_ready_i};
      got_c = {bus.aw_valid_o, bus.aw_ready_o, bus.ar_valid_o, bus.ar_ready_o};
      checks++;
      if (got_c !== exp_c) begin
        errors++; $display("FAIL rand_gate[%0d]: got %b want %b", n, got_c, exp_c);
      end
      tick();
      exp_r = {m_ack, m_idle, m_to, m_err, CW'(m_wr), CW'(m_rd)};
      got_r = {isolate_ack_o, idle_o, timeout_o, err_o, wr_cnt_o, rd_cnt_o};
      checks++;
      if (got_r !== exp_r) begin
        errors++; $display("FAIL rand_regs[%0d]: got %b want %b", n, got_r, exp_r);
      end
    end
    idle_inputs();
    isolate_req_i = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_count();
    test_throttle();
    test_drain();
    test_pending_fence();
    test_timeout();
    test_err();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_isolation_ctrl.md
# noc_isolation_ctrl

Per-port fence controller for one NoC AXI initiator port. It counts outstanding write and read transactions and throttles new address handshakes at a configurable limit. On request it blocks new traffic, drains in-flight transactions and reports the port as isolated, so the port can be safely power-gated or reset. It sits between an initiator's AW/AR channels and the corresponding NoC ingress, and observes the B/R response channels without modifying them.

## Interface
- `MaxOutstanding`, 64: per-direction outstanding limit (≥1).
- `CntWidth`, $clog2(MaxOutstanding+1): counter width (derived; do not override).
- `TimeoutCycles`, 1024: drain cycles before `timeout_o` asserts; 0 disables.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `isolate_req_i` in 1: level request to fence the port.
- `isolate_ack_o` out 1: port fenced and drained.
- `idle_o` out 1: both counters zero, no pending address.
- `timeout_o` out 1: drain exceeded `TimeoutCycles`.
- `err_o` out 1: sticky; response arrived with counter at zero.
- `wr_cnt_o` / `rd_cnt_o` out CntWidth: outstanding counts.
- `aw_valid_i` in, `aw_ready_o` out (initiator side); `aw_valid_o` out, `aw_ready_i` in (NoC side).
- `ar_valid_i` in, `ar_ready_o` out; `ar_valid_o` out, `ar_ready_i` in: same scheme for reads.
- `b_valid_i`, `b_ready_i` in 1: observed write response handshake.
- `r_valid_i`, `r_ready_i`, `r_last_i` in 1: observed read data handshake.

## Operation
- States: RUN, DRAIN, ISOLATED.
- RUN: `isolate_req_i`=1 → DRAIN.
- DRAIN: `isolate_req_i`=0 → RUN (abort). Otherwise, when `idle_o`=1 → ISOLATED.
- ISOLATED: `isolate_req_i`=0 → RUN.
- Gate open, per channel: state RUN and count < `MaxOutstanding`, or a pending address exists.
  - Gate open: `x_valid_o`=`x_valid_i`, `x_ready_o`=`x_ready_i`.
  - Gate closed: both forced 0.
- Pending flag per channel:
  - Set when `x_valid_o`=1 and `x_ready_i`=0.
  - Cleared on handshake.
  - Guarantees AXI valid stability: an address already presented is never withdrawn by fencing or throttling.
- Write counter:
  - +1 on AW handshake (`aw_valid_o`&`aw_ready_i`).
  - −1 on B handshake.
  - Simultaneous +1/−1 → unchanged.
- Read counter:
  - +1 on AR handshake.
  - −1 on R handshake with `r_last_i`=1.
- Decrement at zero: counter stays 0 and `err_o` sets. `err_o` clears only on reset.
- Counters never exceed `MaxOutstanding`, because the gate closes at the limit.
- Timeout counter:
  - Counts cycles in DRAIN and saturates.
  - `timeout_o` asserts when it reaches `TimeoutCycles` and stays high while in DRAIN.
  - Counter and flag clear on leaving DRAIN.
- B/R channels are never gated, so responses always complete.

## Timing
- Reset values: state RUN; counters 0; pending flags 0; `isolate_ack_o`=0; `idle_o`=1; `timeout_o`=0; `err_o`=0; `wr_cnt_o`=`rd_cnt_o`=0.
- Gated `valid_o`/`ready_o` stay combinational from the inputs. Gated outputs are 0 in reset only if the inputs are 0.
- Registered outputs: `isolate_ack_o`, `idle_o`, `timeout_o`, `err_o`, `wr_cnt_o`, `rd_cnt_o`.
- `isolate_req_i` rises at edge t → state DRAIN after t. New, non-pending AW/AR are blocked from cycle t+1.
- Last response handshake at edge t → `idle_o`=1 and state ISOLATED after t+1. `isolate_ack_o`=1 from t+2.
- Already idle at request: `isolate_ack_o`=1 two cycles after `isolate_req_i` rises.
- `isolate_req_i` falls → state RUN next edge. `isolate_ack_o`=0 the cycle after.
- `rst_i` asserted mid-drain: immediate return to reset values. In-flight transactions are lost from counting; system reset sequencing must reset the NoC port too.

## Test plan
- Reset, then 3 AW handshakes and 2 B handshakes → `wr_cnt_o`=1, `idle_o`=0, `err_o`=0.
- `MaxOutstanding`=4: issue 4 ARs with no R → 5th AR sees `ar_ready_o`=0 and `ar_valid_o`=0. One R with `r_last_i`=1 → 5th AR accepted the next cycle.
- 2 writes outstanding, raise `isolate_req_i`, hold new AW → `aw_valid_o`=0. After 2 B handshakes → `isolate_ack_o`=1 exactly 2 cycles after the last B.
- AW stalled (`aw_ready_i`=0) when the request rises → `aw_valid_o` stays 1 until `aw_ready_i`=1, then the counter increments and drain completes.
- `TimeoutCycles`=8 with 1 read never answered → `timeout_o`=1 after 8 DRAIN cycles. Dropping `isolate_req_i` → RUN and `timeout_o`=0 next cycle.
- B handshake with `wr_cnt_o`=0 → `err_o`=1 sticky and `wr_cnt_o` stays 0. Simultaneous AW and B at count 2 → count stays 2.
